// File: rtl/switch_poll_ctrl.sv
// switch_poll_ctrl: polls the switch PIO, debounces samples and queues stable changes for the CPU
module switch_poll_ctrl #(
    parameter int WIDTH      = 17,
    parameter int DEPTH      = 4,
    parameter int STABLE_CNT = 3,
    parameter int PERIOD_RST = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  pio_address,
    input  logic [31:0] pio_readdata,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, SETTLE, SAMPLE} state_t;
    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d, period_q, period_d;
    logic             enable_q, enable_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] cand_q, cand_d, deb_q, deb_d, s;
    logic [3:0]       scnt_q, scnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [4:0]       count_q, count_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             push, pop, full, store;
    logic             unused_bits;

    assign s           = pio_readdata[WIDTH-1:0];
    assign pio_address = 2'b00;
    assign readdata    = readdata_q;
    assign irq         = irq_en_q && (count_q != 5'd0);
    assign unused_bits = ^{pio_readdata[31:WIDTH], writedata[15:9], writedata[7:2]};

    // poll sequencing and debounce; a sample is taken only in SAMPLE while enabled
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        scnt_d  = scnt_q;
        deb_d   = deb_q;
        push    = 1'b0;
        if (!enable_q) begin
            state_d = IDLE;
            scnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    cnt_d   = period_q;
                end
                WAIT: begin
                    state_d = (cnt_q <= 16'd1) ? SETTLE : WAIT;
                    cnt_d   = (cnt_q <= 16'd1) ? cnt_q : cnt_q - 16'd1;
                end
                SETTLE: state_d = SAMPLE;
                default: begin
                    state_d = WAIT;
                    cnt_d   = period_q;
                    cand_d  = s;
                    scnt_d  = (s != cand_q) ? 4'd1 : (scnt_q == 4'(STABLE_CNT)) ? scnt_q : scnt_q + 4'd1;
                    if (scnt_d == 4'(STABLE_CNT) && cand_d != deb_q) begin
                        deb_d = cand_d;
                        push  = 1'b1;
                    end
                end
            endcase
        end
    end

    // event FIFO bookkeeping, CPU register writes and registered read data
    always_comb begin
        pop        = read && address == 2'd0 && count_q != 5'd0;
        full       = count_q == 5'(DEPTH);
        store      = push && (!full || pop);
        wr_d       = wr_q + AW'(store);
        rd_d       = rd_q + AW'(pop);
        count_d    = count_q + {4'b0, store} - {4'b0, pop};
        ovf_d      = (push && full && !pop) ? 1'b1 : (write && address == 2'd2 && writedata[8]) ? 1'b0 : ovf_q;
        enable_d   = (write && address == 2'd1) ? writedata[0] : enable_q;
        irq_en_d   = (write && address == 2'd1) ? writedata[1] : irq_en_q;
        period_d   = !(write && address == 2'd1) ? period_q : (writedata[31:16] == 16'd0) ? 16'd1 : writedata[31:16];
        readdata_d = !read ? readdata_q :
                     address == 2'd0 ? (count_q != 5'd0 ? (32'h8000_0000 | 32'(mem_q[rd_q])) : 32'd0) :
                     address == 2'd1 ? {period_q, 14'b0, irq_en_q, enable_q} :
                     address == 2'd2 ? {23'b0, ovf_q, 3'b0, count_q} : 32'(deb_q);
    end

    // state registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            scnt_q     <= '0;
            deb_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= 16'(PERIOD_RST);
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            scnt_q     <= scnt_d;
            deb_q      <= deb_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            period_q   <= period_d;
            readdata_q <= readdata_d;
        end
    end

    // event storage; entries are only meaningful below count, so no reset is needed
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_q] <= cand_d;
    end
endmodule

// File: tb/tb_switch_poll_ctrl.sv
// tb_switch_poll_ctrl: directed bench with a queue-based behavioural model checked every cycle
module tb_switch_poll_ctrl;
    localparam int DEPTH = 4;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  pio_address;
    logic [31:0] pio_rd;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;
    logic [16:0] in_port = 17'd0;
    int          errors = 0;
    int          checks = 0;

    switch_poll_ctrl #(.WIDTH(17), .DEPTH(DEPTH), .STABLE_CNT(STABLE), .PERIOD_RST(1000)) dut (
        .clk(clk), .reset_n(reset_n), .pio_address(pio_address), .pio_readdata(pio_rd),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // the PIO slave: readdata registered one cycle after the (always zero) address
    always @(posedge clk) pio_rd <= {15'b0, in_port};

    function automatic void check(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endfunction

    // behavioural model: registers, a countdown to the next sample, debounce and an event queue
    logic [16:0] mq[$];
    bit          m_run = 0, m_en = 0, m_ie = 0, m_ovf = 0;
    int          m_left = 0, m_sc = 0;
    logic [15:0] m_p = 16'd1000;
    logic [16:0] m_deb = '0, m_cand = '0;
    logic [31:0] m_rd = '0;

    always @(posedge clk or negedge reset_n) begin
        bit push, pop;
        logic [16:0] smp;
        if (!reset_n) begin
            mq.delete();
            m_run = 0; m_en = 0; m_ie = 0; m_ovf = 0; m_left = 0; m_sc = 0;
            m_p = 16'd1000; m_deb = '0; m_cand = '0; m_rd = '0;
        end else begin
            push = 0;
            smp = pio_rd[16:0];
            if (read)
                m_rd = address == 2'd0 ? (mq.size() != 0 ? {1'b1, 14'b0, mq[0]} : 32'd0) :
                       address == 2'd1 ? {m_p, 14'b0, m_ie, m_en} :
                       address == 2'd2 ? {23'b0, m_ovf, 3'b0, 5'(mq.size())} : {15'b0, m_deb};
            if (!m_en) begin
                m_run = 0;
                m_sc = 0;
            end else if (!m_run) begin
                m_run = 1;
                m_left = int'(m_p) + 1;
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                m_left = int'(m_p) + 1;
                if (smp == m_cand) m_sc = (m_sc < STABLE) ? m_sc + 1 : m_sc;
                else begin
                    m_cand = smp;
                    m_sc = 1;
                end
                if (m_sc == STABLE && m_cand != m_deb) begin
                    m_deb = m_cand;
                    push = 1;
                end
            end
            pop = read && address == 2'd0 && mq.size() != 0;
            if (pop) void'(mq.pop_front());
            if (write && address == 2'd2 && writedata[8]) m_ovf = 0;
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(m_cand);
                else m_ovf = 1;
            end
            if (write && address == 2'd1) begin
                m_en = writedata[0];
                m_ie = writedata[1];
                m_p = (writedata[31:16] == 16'd0) ? 16'd1 : writedata[31:16];
            end
        end
    end

    // every cycle the outputs must agree with the model
    always @(negedge clk) begin
        check("cyc_readdata", readdata, m_rd);
        check("cyc_irq", {31'b0, irq}, {31'b0, m_ie && mq.size() != 0});
        check("cyc_pio_address", {30'b0, pio_address}, 32'd0);
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_pio_address", {30'b0, pio_address}, 32'd0);
        reset_n = 1'b1;
        rd(2'd1, d); check("ctrl_reset", d, 32'h03E8_0000);
        rd(2'd2, d); check("status_reset", d, 32'd0);

        in_port = 17'h1A5A5;
        wr(2'd1, 32'h0004_0003);
        repeat (18) @(negedge clk);
        check("irq_before_event", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check("irq_first_event", {31'b0, irq}, 32'd1);
        rd(2'd0, d); check("event_1a5a5", d, 32'h8001_A5A5);
        rd(2'd3, d); check("stable_1a5a5", d, 32'h0001_A5A5);
        rd(2'd0, d); check("event_empty", d, 32'd0);

        for (int i = 0; i < 8; i++) begin
            in_port = i[0] ? 17'h1 : 17'h0;
            repeat (6) @(negedge clk);
        end
        rd(2'd2, d); check("toggle_no_events", d, 32'd0);

        for (int i = 1; i <= 5; i++) begin
            in_port = 17'(i * 17);
            repeat (30) @(negedge clk);
        end
        rd(2'd2, d); check("status_full_ovf", d, 32'h0000_0104);
        rd(2'd0, d); check("ovf_event0", d, 32'h8000_0011);
        rd(2'd0, d); check("ovf_event1", d, 32'h8000_0022);
        rd(2'd0, d); check("ovf_event2", d, 32'h8000_0033);
        rd(2'd0, d); check("ovf_event3", d, 32'h8000_0044);
        rd(2'd2, d); check("status_ovf_only", d, 32'h0000_0100);
        wr(2'd2, 32'h0000_0100);
        rd(2'd2, d); check("status_ovf_clear", d, 32'd0);

        for (int i = 6; i <= 9; i++) begin
            in_port = 17'(i * 17);
            repeat (30) @(negedge clk);
        end
        wr(2'd1, 32'h0004_0002);
        in_port = 17'h000AA;
        repeat (30) @(negedge clk);
        rd(2'd3, d); check("stable_retained", d, 32'h0000_0099);
        rd(2'd2, d); check("status_full_no_ovf", d, 32'h0000_0004);
        wr(2'd1, 32'h0004_0003);
        repeat (18) @(negedge clk);
        rd(2'd0, d); check("pop_with_push_head", d, 32'h8000_0066);
        rd(2'd2, d); check("pop_with_push_status", d, 32'h0000_0004);
        rd(2'd0, d); check("tail_event0", d, 32'h8000_0077);
        rd(2'd0, d); check("tail_event1", d, 32'h8000_0088);
        rd(2'd0, d); check("tail_event2", d, 32'h8000_0099);
        rd(2'd0, d); check("tail_event3", d, 32'h8000_00AA);

        wr(2'd1, 32'h0000_0002);
        rd(2'd1, d); check("ctrl_p0_as_1", d, 32'h0001_0002);
        in_port = 17'h1FFFF;
        wr(2'd1, 32'h0000_0003);
        repeat (9) @(negedge clk);
        check("p1_irq_before", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check("p1_irq_event", {31'b0, irq}, 32'd1);

        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 32'd0);
        check("async_rst_irq", {31'b0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1, d); check("ctrl_after_rst", d, 32'h03E8_0000);
        rd(2'd2, d); check("status_after_rst", d, 32'd0);
        rd(2'd0, d); check("event_after_rst", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/switch_poll_ctrl.md
# switch_poll_ctrl

Polling and debounce controller for the 17-bit switch PIO input slave. It acts as the PIO's only reader: it samples the slave's `readdata` on a programmable period and debounces the samples. Each stable change is pushed into a small event FIFO, and an interrupt is raised. The CPU sees the block as a 4-word Avalon-MM slave, so software no longer polls the PIO directly.

## Interface
Parameters:
- WIDTH, 17, switch vector width; must match the PIO `in_port` width.
- DEPTH, 4, event FIFO entries; power of two, 2..16.
- STABLE_CNT, 3, consecutive identical samples required to accept a value; range 1..15.
- PERIOD_RST, 1000, reset value of the poll period in clk cycles.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  reset is asynchronous and active-low.
- pio_address  out  2  address to the PIO slave; held at 0 at all times, including reset.
- pio_readdata  in  32  PIO `readdata`, registered in the PIO with 1-cycle latency from the address; bits [WIDTH-1:0] are used.
- address  in  2  CPU slave register select.
- read  in  1  CPU read strobe, one cycle.
- write  in  1  CPU write strobe, one cycle.
- writedata  in  32  CPU write data.
- readdata  out  32  CPU read data; registered, valid the cycle after `read`.
- irq  out  1  level interrupt.

## Operation
Registers:
- addr 0, EVENT (R):
  - Fields: [31] valid, [WIDTH-1:0] the head event's value.
  - A read with valid=1 pops the FIFO.
  - A read when empty returns 0 and does not pop.
- addr 1, CONTROL (R/W):
  - Fields: [0] enable, [1] irq_en, [31:16] period P.
  - Reset value: enable=0, irq_en=0, P=PERIOD_RST.
  - A written P of 0 is treated as 1.
- addr 2, STATUS:
  - Read fields: [4:0] FIFO count, [8] overflow (sticky).
  - Writing 1 to bit 8 clears overflow; other bits are ignored.
- addr 3, STABLE (R): [WIDTH-1:0] current debounced value. Reset value 0.
- Writes to addresses 0 and 3 are ignored.

FSM states: IDLE, WAIT, SETTLE, SAMPLE.
- IDLE: entered from reset. Moves to WAIT with the counter loaded to P when enable=1.
- WAIT: decrements the counter. Moves to SETTLE when the counter reaches 1.
- SETTLE: one cycle, allowing the PIO register to update.
- SAMPLE: captures pio_readdata[WIDTH-1:0] as s, then returns to WAIT with the counter reloaded to P.
- If enable=0 in any state, the FSM returns to IDLE on the next edge. The debounced value, candidate, FIFO and overflow are retained; stable_count is cleared.

Debounce, evaluated in SAMPLE:
- If s equals the candidate, stable_count increments, saturating at STABLE_CNT.
- Otherwise candidate becomes s and stable_count becomes 1.
- When stable_count reaches STABLE_CNT and candidate differs from the debounced value:
  - the debounced value is updated to candidate;
  - an event carrying candidate is pushed.
- Reset values: candidate 0, stable_count 0.

FIFO:
- Push when not full: the entry is stored and count increments.
- Push when full with no pop in the same cycle: the event is dropped and overflow is set.
- Push and pop in the same cycle: both take effect, even when full; count is unchanged and overflow is not set.
- Pointers wrap modulo DEPTH.

irq = irq_en & (count != 0). It deasserts on the cycle after the pop that empties the FIFO.

## Timing
- Reset values of all outputs: readdata 0, irq 0, pio_address 0.
- Poll interval is P+2 cycles (WAIT P, SETTLE 1, SAMPLE 1).
- First sample: P+2 cycles after enable is written.
- A stable change of the switches is reported after at most (STABLE_CNT+1)·(P+2) cycles.
- Push latency: the event is visible at EVENT, in count and on irq one cycle after SAMPLE.
- CPU read latency is 1 cycle. A pop updates the head for a read issued in the next cycle, so back-to-back reads return consecutive events.
- A CONTROL write takes effect on the next edge. A new P applies at the next WAIT reload.
- Asynchronous reset mid-operation clears all state immediately, including the FIFO and overflow.

## Test plan
- Reset, then P=4, enable=1, in_port held at 0x1A5A5 → after 3 samples (18 cycles after the first WAIT) EVENT reads 0x8001A5A5; STABLE reads 0x1A5A5; irq=1 when irq_en=1.
- in_port toggles between 0x00001 and 0x00000 every sample → no events; count stays 0.
- Generate 5 distinct stable changes with no CPU reads, DEPTH=4 → count=4, overflow=1; the reads return the first 4 values in order; writing 0x100 to STATUS clears overflow.
- FIFO full, and a pop coincides with a push in the same cycle → count stays 4, overflow stays 0, and the new value is at the tail.
- enable cleared during WAIT → FSM in IDLE next cycle, no further samples, STABLE retained; re-enable resumes with stable_count restarting at 1.
- Write P=0 → poll interval is 3 cycles. Assert reset_n low mid-SAMPLE → readdata 0, irq 0, count 0, CONTROL back to reset values.
